// File: rtl/usb_data_tx_framer_if.sv
// Packet-framer bus: scheduler-side request/payload stream, serializer-side byte stream, status.
// The master drives requests, payload and tx_ready; the slave is the framer.
interface usb_data_tx_framer_if;
  logic       tx_start;
  logic [3:0] tx_pid;
  logic       tx_has_data;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_zlp;
  logic       s_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_sop;
  logic       tx_eop;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       len_err;

  modport master (
    output tx_start, tx_pid, tx_has_data, s_data, s_valid, s_last, s_zlp, tx_ready,
    input  s_ready, tx_data, tx_valid, tx_sop, tx_eop, busy, done, len_err
  );

  modport slave (
    input  tx_start, tx_pid, tx_has_data, s_data, s_valid, s_last, s_zlp, tx_ready,
    output s_ready, tx_data, tx_valid, tx_sop, tx_eop, busy, done, len_err
  );
endinterface

// File: rtl/usb_data_tx_framer.sv
// USB transmit framer: emits PID, optional payload and CRC16 trailer as a byte stream
// through a single full-throughput output register.
module usb_data_tx_framer #(
  parameter int unsigned MaxPayload = 1023
) (
  input logic                 clk_i,
  input logic                 reset_i,
  usb_data_tx_framer_if.slave bus
);

  localparam int unsigned CntW = $clog2(MaxPayload + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxPayload);

  // The PID byte is loaded directly on the accepted tx_start, so no separate PID state is needed.
  typedef enum logic [2:0] {StIdle, StData, StCrcLo, StCrcHi, StWaitEnd} state_e;

  state_e          state_q;
  logic [15:0]     crc_q;
  logic [CntW-1:0] cnt_q;
  logic            trunc_q;
  logic [7:0]      out_data_q;
  logic            out_valid_q;
  logic            out_sop_q;
  logic            out_eop_q;
  logic            busy_q;
  logic            done_q;
  logic            len_err_q;

  logic            load_ok;
  logic            accept;
  logic [15:0]     crc_d;
  logic [CntW-1:0] cnt_d;

  // Reflected CRC-16 (poly 0xA001), data bits consumed LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  assign load_ok = !out_valid_q || bus.tx_ready;
  assign accept  = (state_q == StData) && load_ok && bus.s_valid;
  assign crc_d   = crc16_byte(crc_q, bus.s_data);
  assign cnt_d   = cnt_q + 1'b1;

  assign bus.s_ready  = (state_q == StData) && load_ok;
  assign bus.tx_data  = out_data_q;
  assign bus.tx_valid = out_valid_q;
  assign bus.tx_sop   = out_valid_q && out_sop_q;
  assign bus.tx_eop   = out_valid_q && out_eop_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.len_err  = len_err_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      crc_q       <= 16'hFFFF;
      cnt_q       <= '0;
      trunc_q     <= 1'b0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      len_err_q <= 1'b0;
      if (out_valid_q && bus.tx_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        StIdle: begin
          if (bus.tx_start) begin
            crc_q       <= 16'hFFFF;
            cnt_q       <= '0;
            trunc_q     <= 1'b0;
            busy_q      <= 1'b1;
            out_data_q  <= {~bus.tx_pid, bus.tx_pid};
            out_valid_q <= 1'b1;
            out_sop_q   <= 1'b1;
            out_eop_q   <= ~bus.tx_has_data;
            if (!bus.tx_has_data) begin
              state_q <= StWaitEnd;
            end else if (bus.s_zlp) begin
              state_q <= StCrcLo;
            end else begin
              state_q <= StData;
            end
          end
        end
        StData: begin
          if (accept) begin
            out_data_q  <= bus.s_data;
            out_valid_q <= 1'b1;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            crc_q       <= crc_d;
            cnt_q       <= cnt_d;
            if (bus.s_last) begin
              state_q <= StCrcLo;
            end else if (cnt_d == MaxCnt) begin
              trunc_q <= 1'b1;
              state_q <= StCrcLo;
            end
          end
        end
        StCrcLo: begin
          if (load_ok) begin
            out_data_q  <= ~crc_q[7:0];
            out_valid_q <= 1'b1;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            state_q     <= StCrcHi;
          end
        end
        StCrcHi: begin
          if (load_ok) begin
            out_data_q  <= ~crc_q[15:8];
            out_valid_q <= 1'b1;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b1;
            state_q     <= StWaitEnd;
          end
        end
        StWaitEnd: begin
          if (out_valid_q && bus.tx_ready) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            len_err_q <= trunc_q;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/usb_data_tx_framer.md
Name: usb_data_tx_framer

Overview:
- Transmit-side packet encoder for the SIE. Builds one USB packet as a byte stream for the NRZI/bit-stuff serializer.
- Packet format: PID byte, then optional payload bytes, then a 16-bit CRC16 trailer.
- It is the counterpart of the receive-side CRC16 packet checker, so any packet it emits passes that checker.
- Inputs come from the host-controller packet scheduler (PID, payload stream). Output goes to the serializer byte interface.

Parameters:
- MAX_PAYLOAD, 1023, maximum payload bytes per packet (USB full-speed isochronous limit); sets byte-counter width to clog2(MAX_PAYLOAD+1).

Ports:
- clk  input  1  single clock
- reset  input  1  synchronous, active-high reset
- tx_start  input  1  request to start a packet; sampled only in IDLE
- tx_pid  input  4  PID code; captured on accepted tx_start
- tx_has_data  input  1  1 = DATA packet (payload + CRC16), 0 = PID-only handshake packet; captured with tx_start
- s_data  input  8  payload byte
- s_valid  input  1  payload byte valid
- s_last  input  1  marks final payload byte (qualified by s_valid)
- s_zlp  input  1  zero-length DATA packet; sampled with tx_start when tx_has_data=1
- s_ready  output  1  framer accepts s_data this cycle
- tx_data  output  8  byte to serializer
- tx_valid  output  1  tx_data valid
- tx_sop  output  1  first byte of packet (with tx_valid)
- tx_eop  output  1  last byte of packet (with tx_valid)
- tx_ready  input  1  serializer consumes byte when tx_valid && tx_ready
- busy  output  1  high from accepted tx_start until the last byte is consumed
- done  output  1  one-cycle pulse the cycle after the last byte is consumed
- len_err  output  1  one-cycle pulse with done when payload was truncated at MAX_PAYLOAD

Behaviour:
- Reset (synchronous, active-high; overrides everything, including mid-packet):
  - state=IDLE; output register empty; CRC register=16'hFFFF; byte count=0.
  - All outputs 0 except tx_data=8'h00. A packet in flight is abandoned with no done pulse.
- Output stage: a single byte register drives tx_data/tx_valid/tx_sop/tx_eop. It loads a new byte when empty or when its current byte is consumed in the same cycle, giving full throughput of one byte per clock.
- States and transitions:
  - IDLE: tx_start=1 → capture pid/has_data/zlp, clear CRC to FFFF and count to 0, busy=1 → PID.
  - PID: load {~tx_pid, tx_pid}, tx_sop=1.
    - has_data=0: tx_eop=1 → WAIT_END.
    - has_data=1 and zlp=1 → CRC_LO.
    - has_data=1 and zlp=0 → DATA.
  - DATA: s_ready = output stage can load. Each accepted s_data is loaded to the output and the CRC register is updated with that byte in the same cycle. Count increments.
    - s_last=1 → CRC_LO.
    - Count reaches MAX_PAYLOAD without s_last → set truncation flag, → CRC_LO.
  - CRC_LO: load V[7:0] → CRC_HI.
  - CRC_HI: load V[15:8] with tx_eop=1 → WAIT_END.
  - WAIT_END: when the EOP byte is consumed → busy=0, done=1 (len_err=flag) next cycle → IDLE.
- CRC: CRC-16/USB.
  - Polynomial x^16+x^15+x^2+1, reflected form 0xA001, init FFFF, byte-parallel update.
  - Each data byte is processed LSB first.
  - Transmitted value V = ~R (R = final register), low byte first.
  - Receiver residual over payload+CRC is the USB constant (0x800D normal / 0xB001 reflected).
  - PID byte is not covered by the CRC.
- s_ready=0 in every state other than DATA. s_data outside DATA is ignored.
- tx_start while busy is ignored (no queueing).
- Latency: from tx_start in IDLE, tx_valid with the PID byte appears 1 cycle later.
- Serializer backpressure: tx_valid and tx_data hold stable while tx_ready=0. No byte is ever dropped or duplicated.
- s_valid gaps in DATA: tx_valid drops after the held byte is consumed, and the packet continues when s_valid returns. Gap-free delivery is the scheduler's responsibility.

Test Plan:
- Handshake: tx_start, pid=4'h2 (ACK), has_data=0, tx_ready=1 → single byte 8'hD2 with sop=eop=1; done pulse 2 cycles after start; no CRC bytes.
- DATA0 "123456789": pid=4'h3, payload 31..39, tx_ready=1 → bytes C3,31..39,C8,B4; 12 consecutive tx_valid cycles; eop on B4.
- Zero-length: pid=4'hB (DATA1), zlp=1 → bytes 4B,00,00; s_ready never asserted.
- Backpressure: repeat "123456789" with tx_ready toggling pseudo-randomly and s_valid gaps → identical byte sequence; tx_data stable while tx_valid && !tx_ready.
- Truncation: MAX_PAYLOAD=4, 6 bytes with no s_last → exactly 4 payload bytes, then CRC of those 4 bytes; len_err=1 with done; s_ready low after the 4th byte.
- Reset mid-DATA: assert reset for 1 cycle after 3 payload bytes → next cycle busy=0, tx_valid=0; a new packet starts cleanly with CRC init FFFF (check via "123456789" → C8,B4).
